data_mem_pipe: RTL

//  Parametrised single-port data memory for the RV32i load/store unit. Uses a req/gnt/rvalid

---
 rtl/data_mem_pipe_pkg.sv | 39 +++
 rtl/dmem_resp_fifo.sv | 74 +++++++
 rtl/data_mem_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : data_mem_pipe_pkg                                            |
// | Description : Shared defaults and helpers for the data_mem_pipe slice.     |
// |               Holds the default geometry of the data memory and a helper  |
// |               that recognises contiguous byte-enable masks.                |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package data_mem_pipe_pkg;

  localparam int MEM_ADDR_WIDTH   = 12;
  localparam int MEM_DATA_WIDTH   = 32;
  localparam int MEM_WORDS        = 1 << (MEM_ADDR_WIDTH - 2);
  localparam int MEM_READ_LATENCY = 1;
  localparam int MEM_RESP_DEPTH   = 4;

  // True when all set bits of the mask form one unbroken run (an empty mask
  // also counts as contiguous; callers treat the zero mask separately).
  function automatic logic be_contiguous(input logic [63:0] be);
    logic started;
    logic ended;
    logic ok;
    started = 1'b0;
    ended   = 1'b0;
    ok      = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (be[i]) begin
        if (ended) ok = 1'b0;
        started = 1'b1;
      end else if (started) begin
        ended = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_resp_fifo                                               |
// | Description : Synchronous response FIFO for data_mem_pipe. Head entry is  |
// |               presented combinationally on dout. A push and a pop in the  |
// |               same cycle are legal even when full. Pointers wrap modulo    |
// |               DEPTH, so DEPTH need not be a power of two.                  |
// | Ports       : clk, rst (sync, active-high), push, pop, din[WIDTH],         |
// |               dout[WIDTH], empty, full                                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one leaving this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_pipe                                                |
// | Description : Single-port data memory with req/gnt/rvalid handshake,       |
// |               byte-enable writes, pipelined reads and in-order responses.  |
// |               Up to RESP_DEPTH requests may be outstanding; a credit       |
// |               counter throttles gnt_o so the response FIFO never overflows.|
// | Ports       : clk, rst (sync, active-high)                                 |
// |               req_i, gnt_o, we_i, addr_i, be_i, wdata_i   (request side)   |
// |               rvalid_o, rready_i, rdata_o, err_o          (response side)  |
// | Options     : DMEM_ERR_EN - flag out-of-range and misaligned requests on   |
// |               err_o; when undefined err_o is tied low.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_DEPTH    = 1 << (ADDR_WIDTH - 2),
  parameter int READ_LATENCY = MEM_READ_LATENCY,
  parameter int RESP_DEPTH   = MEM_RESP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int WORD_SHIFT = $clog2(BE_WIDTH);
  localparam int IDX_W      = ADDR_WIDTH - WORD_SHIFT;
  localparam int MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam int RESP_W     = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      word_idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  in_range;
  logic                  accept;
  logic                  pop;
  logic [BE_WIDTH-1:0]   be_eff;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  err_flag;
  logic                  push;
  logic [RESP_W-1:0]     push_data;
  logic [RESP_W-1:0]     head;
  logic                  fifo_empty;
  logic                  fifo_full_unused;

  assign word_idx = addr_i[ADDR_WIDTH-1:WORD_SHIFT];
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign in_range = (32'(word_idx) < 32'(MEM_DEPTH));

  // Credit counter covers both in-flight pipeline entries and queued FIFO
  // entries, so a grant always implies a free FIFO slot at push time.
  assign gnt_o  = !rst && (cnt_q != CNT_W'(RESP_DEPTH));
  assign accept = req_i && gnt_o;
  assign pop    = rvalid_o && rready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A zero byte-enable mask means a full-word write.
  assign be_eff = (be_i == '0) ? '1 : be_i;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be_eff[b]) mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rd_word = (!we_i && in_range) ? mem_q[mem_idx] : '0;

`ifdef DMEM_ERR_EN
  always_comb begin
    err_flag = !in_range;
    if (we_i) begin
      if (be_i != '0 && !be_contiguous(64'(be_i))) err_flag = 1'b1;
    end else if (addr_i[WORD_SHIFT-1:0] != '0) begin
      err_flag = 1'b1;
    end
  end
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[WORD_SHIFT-1:0];
  assign err_flag        = 1'b0;
`endif

  // Response pipeline: READ_LATENCY-1 register stages ahead of the FIFO.
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign push      = accept;
      assign push_data = {err_flag, rd_word};
    end else begin : g_pipe
      localparam int STAGES = READ_LATENCY - 1;
      logic [STAGES-1:0] vld_q, vld_d;
      logic [RESP_W-1:0] dat_q [STAGES];
      logic [RESP_W-1:0] dat_d [STAGES];

      always_comb begin
        vld_d[0] = accept;
        dat_d[0] = {err_flag, rd_word};
        for (int s = 1; s < STAGES; s++) begin
          vld_d[s] = vld_q[s-1];
          dat_d[s] = dat_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          for (int s = 0; s < STAGES; s++) dat_q[s] <= '0;
        end else begin
          vld_q <= vld_d;
          for (int s = 0; s < STAGES; s++) dat_q[s] <= dat_d[s];
        end
      end

      assign push      = vld_q[STAGES-1];
      assign push_data = dat_q[STAGES-1];
    end
  endgenerate

  dmem_resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full_unused)
  );

  // Outputs are masked while empty so un-reset FIFO storage never leaks out.
  assign rvalid_o = !fifo_empty;
  assign rdata_o  = rvalid_o ? head[DATA_WIDTH-1:0] : '0;
  assign err_o    = rvalid_o ? head[DATA_WIDTH] : 1'b0;

endmodule
`default_nettype wire
